i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one I2C bus master (the i2c_main/i2c_clk_divider pair) among NUM_REQ on-chip requesters. Each requester presents a single-byte transaction (7-bit address, R/W, write data). The arbiter grants one requester, latches its fields and pulses the master's start. It waits for completion, then returns read data and NACK status to the granted requester. It sits between client logic and the I2C master, in the same clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 65535, watchdog limit in clk cycles for m_done (used only with I2C_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester request; held high until that requester's done pulse
req_addr  in  7*NUM_REQ  packed 7-bit slave addresses, requester i at [7i+6:7i]
req_rw  in  NUM_REQ  1 = read, 0 = write
req_wdata  in  8*NUM_REQ  packed write bytes, requester i at [8i+7:8i]
gnt  out  NUM_REQ  one-hot grant, high from grant to done inclusive
done  out  NUM_REQ  one-cycle completion pulse to granted requester
rdata  out  8  read byte, valid in the done cycle, held until next done
nack  out  1  slave NACK status, valid in the done cycle, held until next done
timeout  out  1  watchdog abort flag, valid in the done cycle (0 when macro absent)
m_start  out  1  one-cycle start pulse to master
m_addr  out  7  latched address to master
m_rw  out  1  latched R/W to master
m_wdata  out  8  latched write byte to master
m_busy  in  1  master busy
m_done  in  1  master completion pulse
m_rdata  in  8  master read byte
m_nack  in  1  master NACK status

Behaviour:
- Reset (async, any state): state=IDLE; gnt, done, m_start, nack, timeout = 0; rdata, m_addr, m_rw, m_wdata = 0; rr pointer = NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, ISSUE, WAIT_DONE, COMPLETE.
- IDLE: if req != 0, select the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap. At the edge: gnt[sel]=1; latch req_addr/req_rw/req_wdata[sel] into m_*; ptr=sel; go to ISSUE. Selection is combinational on the req sampled in IDLE.
- ISSUE: while m_busy=1, hold. When m_busy=0, m_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: m_done is honoured only in this state. On m_done=1: latch rdata=m_rdata (m_rw=1) or 0 (m_rw=0), nack=m_nack, timeout=0; go to COMPLETE.
- COMPLETE: done[ptr]=1 for one cycle; gnt cleared at the end of this cycle; go to IDLE.
- Latency: req high in IDLE at edge N gives gnt at N+1, m_start at N+1..N+2 (if m_busy=0), done one cycle after the edge that sampled m_done.
- Minimum one IDLE cycle between transactions. A requester still holding req after its done is lowest priority next round.
- Simultaneous requests: strict round-robin. With all req high, grant order is 0,1,2,3,0,...
- req dropping after grant: ignored; the transaction completes and done is still pulsed.
- m_done outside WAIT_DONE: ignored.
- Reset mid-transaction: all outputs return to reset values immediately; the master is reset by the same reset.

Optional Feature:
I2C_ARB_TIMEOUT_EN:
- Defined: 16-bit watchdog counter cleared on entry to WAIT_DONE and incremented each cycle there. On reaching TIMEOUT with no m_done: go to COMPLETE with timeout=1, nack=1, rdata=0. The bus is still released.
- Undefined: no counter, timeout tied 0, and WAIT_DONE waits indefinitely.

Test Plan:
- Write test: req[0]=1, addr 0x50, rw=0, wdata 0xA5. Expect gnt=0001, one m_start with m_addr=0x50, m_wdata=0xA5. After model m_done with m_nack=0: done[0] pulse, nack=0, gnt=0.
- Read test: req[2], addr 0x68, rw=1. Model returns m_rdata=0x3C. Expect done[2] pulse with rdata=0x3C.
- Round-robin: req=1111 held after each done. Expect grant sequence 0,1,2,3,0, each exactly one m_start and one IDLE gap.
- NACK and busy: m_busy=1 for 20 cycles at grant. Expect m_start delayed until m_busy=0. m_nack=1 on completion gives nack=1 in the done cycle.
- Reset mid-transaction: assert reset in WAIT_DONE. Expect gnt=0, done=0, m_start=0 asynchronously. After release, req[1] is granted first if req[0]=0.
- Timeout (macro on, TIMEOUT=100): never pulse m_done. Expect done pulse 100–102 cycles after m_start with timeout=1, nack=1.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin arbiter and single-byte transaction sequencer
// sharing one I2C master among NUM_REQ requesters.
// Optional build macro I2C_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog
// (TIMEOUT cycles); without it, timeout stays 0 and the arbiter waits forever.
module i2c_bus_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rdata,
    output logic                 nack,
    output logic                 timeout,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic                 m_rw,
    output logic [7:0]           m_wdata,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic [7:0]           m_rdata,
    input  logic                 m_nack
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       sel;
    logic                sel_valid;
    logic [NUM_REQ-1:0]  ptr_onehot;
    logic                wd_expired;

    // Round-robin search: first pending request after the last granted one, with wrap
    always_comb begin : sel_search
        logic [PW-1:0] idx_p;
        sel       = '0;
        sel_valid = 1'b0;
        idx_p     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx_p = PW'((32'(ptr) + i) % NUM_REQ);
            if (!sel_valid && req[idx_p]) begin
                sel       = idx_p;
                sel_valid = 1'b1;
            end
        end
    end

    // One-hot decode of the currently granted requester
    always_comb begin
        ptr_onehot      = '0;
        ptr_onehot[ptr] = 1'b1;
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Watchdog: cleared while issuing, counts every cycle spent in WAIT_DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    // Expiry on the TIMEOUT-th cycle in WAIT_DONE
    always_comb begin
        wd_expired = (state == WAIT_DONE) && (wd_cnt == 16'(TIMEOUT - 1));
    end
`else
    // No watchdog: WAIT_DONE only leaves on m_done
    always_comb begin
        wd_expired = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus grant/start/done strobes derived from state
    always_comb begin
        state_next = state;
        gnt        = '0;
        done       = '0;
        m_start    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                gnt = ptr_onehot;
                if (!m_busy) begin
                    m_start    = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                gnt = ptr_onehot;
                if (m_done || wd_expired) begin
                    state_next = COMPLETE;
                end
            end
            COMPLETE: begin
                gnt        = ptr_onehot;
                done       = ptr_onehot;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch the winner's transaction on grant, capture results on completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= PW'(NUM_REQ - 1);
            m_addr  <= '0;
            m_rw    <= 1'b0;
            m_wdata <= '0;
            rdata   <= '0;
            nack    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE && sel_valid) begin
                ptr     <= sel;
                m_addr  <= req_addr[7*32'(sel) +: 7];
                m_rw    <= req_rw[sel];
                m_wdata <= req_wdata[8*32'(sel) +: 8];
            end
            if (state == WAIT_DONE) begin
                if (m_done) begin
                    rdata   <= m_rw ? m_rdata : '0;
                    nack    <= m_nack;
                    timeout <= 1'b0;
                end else if (wd_expired) begin
                    rdata   <= '0;
                    nack    <= 1'b1;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: table-driven directed bench for i2c_bus_arbiter with a
// behavioural I2C master driven inline; watchdog sequence built only with
// I2C_ARB_TIMEOUT_EN.
module tb_i2c_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [27:0] req_addr = '0;
    logic [3:0]  req_rw = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  rdata;
    logic        nack;
    logic        timeout;
    logic        m_start;
    logic [6:0]  m_addr;
    logic        m_rw;
    logic [7:0]  m_wdata;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [7:0]  m_rdata = '0;
    logic        m_nack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_bus_arbiter #(.NUM_REQ(4), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_rw(req_rw), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .nack(nack), .timeout(timeout), .m_start(m_start),
        .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata), .m_busy(m_busy),
        .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        int unsigned sel;
        logic [6:0]  addr;
        logic        rw;
        logic [7:0]  wdata;
        int unsigned busy;
        logic        drop;
        logic [7:0]  m_rd;
        logic        m_nk;
        logic [7:0]  exp_rd;
        logic        exp_nk;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expired(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic load_fields(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            req_addr[7*i +: 7]  = 7'h10 + 7'(i);
            req_wdata[8*i +: 8] = 8'hE0 + 8'(i);
            req_rw[i]           = 1'b0;
        end
        req_addr[7*v.sel +: 7]  = v.addr;
        req_wdata[8*v.sel +: 8] = v.wdata;
        req_rw[v.sel]           = v.rw;
    endtask

    // Full transaction: called in an IDLE cycle, returns in the following IDLE cycle
    task automatic run_txn(input vec_t v);
        logic [31:0] exp_g;
        bit          got;
        exp_g = 32'd1 << v.sel;
        load_fields(v);
        req    = v.mask;
        m_busy = (v.busy != 0);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (gnt != 0) begin got = 1; break; end
        end
        if (!got) begin expired("gnt_wait"); return; end
        chk("gnt", gnt, exp_g);
        if (v.drop) req = '0;
        // busy hold; a stray m_done in ISSUE must be ignored
        for (int k = 0; k < int'(v.busy); k++) begin
            chk("start_held", m_start, 0);
            m_done = (k == 5);
            @(posedge clk); #1;
        end
        m_done = 1'b0;
        m_busy = 1'b0;
        #1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (m_start) begin got = 1; break; end
            @(posedge clk); #1;
        end
        if (!got) begin expired("start_wait"); return; end
        chk("m_addr", m_addr, v.addr);
        chk("m_rw", m_rw, v.rw);
        chk("m_wdata", m_wdata, v.wdata);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("start_once", m_start, 0);
            chk("done_early", done, 0);
        end
        m_rdata = v.m_rd;
        m_nack  = v.m_nk;
        m_done  = 1'b1;
        @(posedge clk); #1;
        m_done  = 1'b0;
        m_rdata = 8'h5A;
        m_nack  = ~v.m_nk;
        chk("done", done, exp_g);
        chk("rdata", rdata, v.exp_rd);
        chk("nack", nack, v.exp_nk);
        chk("timeout", timeout, 0);
        chk("gnt_done", gnt, exp_g);
        @(posedge clk); #1;
        chk("done_clr", done, 0);
        chk("gnt_clr", gnt, 0);
        chk("rdata_hold", rdata, v.exp_rd);
        chk("nack_hold", nack, v.exp_nk);
    endtask

    initial begin
        //          mask    sel addr   rw wdata  busy drop m_rd  nk  exp_rd exp_nk
        vecs[0]  = '{4'b0001, 0, 7'h50, 0, 8'hA5, 0,  0, 8'hFF, 0, 8'h00, 0};
        vecs[1]  = '{4'b0100, 2, 7'h68, 1, 8'h00, 0,  0, 8'h3C, 0, 8'h3C, 0};
        vecs[2]  = '{4'b1000, 3, 7'h2A, 1, 8'h11, 0,  0, 8'h81, 1, 8'h81, 1};
        vecs[3]  = '{4'b1111, 0, 7'h21, 0, 8'h10, 0,  0, 8'h99, 0, 8'h00, 0};
        vecs[4]  = '{4'b1111, 1, 7'h22, 1, 8'h20, 0,  0, 8'h42, 0, 8'h42, 0};
        vecs[5]  = '{4'b1111, 2, 7'h23, 0, 8'h30, 0,  0, 8'h77, 1, 8'h00, 1};
        vecs[6]  = '{4'b1111, 3, 7'h24, 1, 8'h40, 0,  0, 8'hC3, 0, 8'hC3, 0};
        vecs[7]  = '{4'b1111, 0, 7'h25, 1, 8'h50, 0,  0, 8'h0F, 0, 8'h0F, 0};
        vecs[8]  = '{4'b0010, 1, 7'h3B, 0, 8'h5E, 20, 0, 8'h66, 1, 8'h00, 1};
        vecs[9]  = '{4'b0110, 2, 7'h44, 1, 8'h01, 0,  0, 8'h18, 0, 8'h18, 0};
        vecs[10] = '{4'b0011, 0, 7'h45, 0, 8'h7E, 0,  0, 8'h00, 0, 8'h00, 0};
        vecs[11] = '{4'b1001, 3, 7'h46, 1, 8'h02, 0,  0, 8'hFE, 1, 8'hFE, 1};
        vecs[12] = '{4'b0010, 1, 7'h47, 1, 8'h03, 0,  1, 8'h5C, 0, 8'h5C, 0};

        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_start", m_start, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_nack", nack, 0);
        chk("rst_timeout", timeout, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) run_txn(vecs[i]);

        // m_done while IDLE must not produce a completion
        req    = '0;
        m_done = 1'b1;
        @(posedge clk); #1;
        m_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("idle_mdone_done", done, 0);
            chk("idle_mdone_gnt", gnt, 0);
            @(posedge clk); #1;
        end

`ifdef I2C_ARB_TIMEOUT_EN
        begin : wd_seq
            bit got;
            int cyc;
            req_addr[6:0] = 7'h33;
            req_rw[0]     = 1'b1;
            req = 4'b0001;
            got = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (m_start) begin got = 1; break; end
            end
            if (!got) expired("wd_start_wait");
            else begin
                req = '0;
                cyc = 0;
                got = 0;
                for (int k = 0; k < 200; k++) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (done != 0) begin got = 1; break; end
                end
                if (!got) expired("wd_done_wait");
                else begin
                    n_cmp++;
                    if (cyc < 100 || cyc > 102) begin
                        n_bad++;
                        $display("FAIL wd_latency: got %0d expected 100..102", cyc);
                    end
                    chk("wd_done", done, 4'b0001);
                    chk("wd_timeout", timeout, 1);
                    chk("wd_nack", nack, 1);
                    chk("wd_rdata", rdata, 0);
                    @(posedge clk); #1;
                    chk("wd_gnt_clr", gnt, 0);
                end
            end
        end
`endif

        // Reset in WAIT_DONE, then priority restarts from requester 0
        begin : rst_seq
            bit   got;
            vec_t v;
            v = '{4'b0001, 0, 7'h5D, 1, 8'h9A, 0, 0, 8'h00, 0, 8'h00, 0};
            load_fields(v);
            req = 4'b0001;
            got = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (m_start) begin got = 1; break; end
            end
            if (!got) expired("rst_start_wait");
            @(posedge clk); #1;
            chk("pre_rst_gnt", gnt, 4'b0001);
            #2;
            reset = 1'b1;
            #1;
            chk("arst_gnt", gnt, 0);
            chk("arst_done", done, 0);
            chk("arst_start", m_start, 0);
            chk("arst_m_addr", m_addr, 0);
            chk("arst_m_rw", m_rw, 0);
            chk("arst_rdata", rdata, 0);
            chk("arst_nack", nack, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            req   = '0;
            v = '{4'b0110, 1, 7'h61, 0, 8'hC7, 0, 0, 8'hAA, 0, 8'h00, 0};
            run_txn(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
